multicycle_ctrl: RTL and testbench

- Multicycle control unit for the RV32I-subset core.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states.
- Drives the datapath muxes and write strobes.
- Produces the 3-bit alu_control consumed by the ALU and uses the ALU's zero flag to resolve beq.

---
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset core: sequences each instruction
// and drives datapath mux selects, write strobes and the 3-bit ALU control.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    state_t     state_q, state_d;
    logic       pc_update, branch;
    logic       adr_src_r, mem_write_r, ir_write_r, reg_write_r, illegal_r;
    logic [1:0] result_src_r, alu_src_a_r, alu_src_b_r, imm_src_r;
    aluop_t     aluop;

    function automatic logic funct3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Subtract only for register-register ops with instr[30] set; addi ignores it.
    function automatic logic [2:0] alu_decode(input aluop_t aop, input logic op5,
                                              input logic [2:0] f3, input logic f7b5);
        logic [2:0] ctl;
        ctl = 3'b000;
        case (aop)
            ALUOP_ADD: ctl = 3'b000;
            ALUOP_SUB: ctl = 3'b001;
            default: begin
                case (f3)
                    3'b000:  ctl = (op5 & f7b5) ? 3'b001 : 3'b000;
                    3'b010:  ctl = 3'b101;
                    3'b110:  ctl = 3'b011;
                    3'b111:  ctl = 3'b010;
                    default: ctl = 3'b000;
                endcase
            end
        endcase
        return ctl;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = FETCH;
        pc_update    = 1'b0;
        branch       = 1'b0;
        adr_src_r    = 1'b0;
        mem_write_r  = 1'b0;
        ir_write_r   = 1'b0;
        reg_write_r  = 1'b0;
        illegal_r    = 1'b0;
        result_src_r = 2'b00;
        alu_src_a_r  = 2'b00;
        alu_src_b_r  = 2'b00;
        aluop        = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                ir_write_r   = 1'b1;
                alu_src_b_r  = 2'b10;
                result_src_r = 2'b10;
                pc_update    = 1'b1;
                state_d      = DECODE;
            end
            DECODE: begin
                alu_src_a_r = 2'b01;
                alu_src_b_r = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d   = FETCH;
                        illegal_r = 1'b1;
                    end
                endcase
                if ((op == OP_R || op == OP_I) && !funct3_ok(funct3)) illegal_r = 1'b1;
            end
            MEMADR: begin
                alu_src_a_r = 2'b10;
                alu_src_b_r = 2'b01;
                state_d     = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src_r = 1'b1;
                state_d   = MEMWB;
            end
            MEMWB: begin
                result_src_r = 2'b01;
                reg_write_r  = 1'b1;
            end
            MEMWRITE: begin
                adr_src_r   = 1'b1;
                mem_write_r = 1'b1;
            end
            EXECUTER: begin
                alu_src_a_r = 2'b10;
                aluop       = ALUOP_FUNCT;
                state_d     = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a_r = 2'b10;
                alu_src_b_r = 2'b01;
                aluop       = ALUOP_FUNCT;
                state_d     = ALUWB;
            end
            ALUWB: reg_write_r = 1'b1;
            BEQ: begin
                alu_src_a_r = 2'b10;
                aluop       = ALUOP_SUB;
                branch      = 1'b1;
            end
            JAL: begin
                alu_src_a_r = 2'b01;
                alu_src_b_r = 2'b10;
                pc_update   = 1'b1;
                state_d     = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_LW, OP_I: imm_src_r = 2'b00;
            OP_SW:       imm_src_r = 2'b01;
            OP_BEQ:      imm_src_r = 2'b10;
            OP_JAL:      imm_src_r = 2'b11;
            default:     imm_src_r = 2'b00;
        endcase
    end

    // Every output is forced low while rst_n is low so no strobe escapes during reset.
    assign pc_write    = rst_n & (pc_update | (branch & zero));
    assign adr_src     = rst_n & adr_src_r;
    assign mem_write   = rst_n & mem_write_r;
    assign ir_write    = rst_n & ir_write_r;
    assign reg_write   = rst_n & reg_write_r;
    assign illegal     = rst_n & illegal_r;
    assign result_src  = {2{rst_n}} & result_src_r;
    assign alu_src_a   = {2{rst_n}} & alu_src_a_r;
    assign alu_src_b   = {2{rst_n}} & alu_src_b_r;
    assign imm_src     = {2{rst_n}} & imm_src_r;
    assign alu_control = {3{rst_n}} & alu_decode(aluop, op[5], funct3, funct7b5);
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle comparison against an
// instruction-level model plus literal spot checks.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .imm_src(imm_src),
        .alu_control(alu_control), .illegal(illegal), .state(state)
    );

    // Per-state Moore outputs: pcu br adr mw irw | result_src alu_src_a alu_src_b | reg_write aluop
    typedef struct packed {
        logic pcu; logic br; logic adr; logic mw; logic irw;
        logic [1:0] rs; logic [1:0] sa; logic [1:0] sb;
        logic rw; logic [1:0] aop;
    } row_t;

    function automatic row_t state_row(input logic [3:0] st);
        case (st)
            4'd0:  return {5'b10001, 2'b10, 2'b00, 2'b10, 1'b0, 2'd0};
            4'd1:  return {5'b00000, 2'b00, 2'b01, 2'b01, 1'b0, 2'd0};
            4'd2:  return {5'b00000, 2'b00, 2'b10, 2'b01, 1'b0, 2'd0};
            4'd3:  return {5'b00100, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0};
            4'd4:  return {5'b00000, 2'b01, 2'b00, 2'b00, 1'b1, 2'd0};
            4'd5:  return {5'b00110, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0};
            4'd6:  return {5'b00000, 2'b00, 2'b10, 2'b00, 1'b0, 2'd2};
            4'd7:  return {5'b00000, 2'b00, 2'b10, 2'b01, 1'b0, 2'd2};
            4'd8:  return {5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0};
            4'd9:  return {5'b01000, 2'b00, 2'b10, 2'b00, 1'b0, 2'd1};
            4'd10: return {5'b10000, 2'b00, 2'b01, 2'b10, 1'b0, 2'd0};
            default: return '0;
        endcase
    endfunction

    function automatic logic legal_op(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input logic [1:0] aop, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7);
        if (aop == 2'd0) return 3'b000;
        if (aop == 2'd1) return 3'b001;
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    logic       m_valid = 1'b0;
    logic       m_rst = 1'b0;
    logic [3:0] m_st = 4'd0;

    always @(negedge clk) begin
        if (m_valid) begin : cmp
            row_t r;
            logic g, e_ill;
            r = state_row(m_st);
            g = m_rst;
            e_ill = (m_st == 4'd1) && (!legal_op(op) ||
                    ((op == 7'b0110011 || op == 7'b0010011) &&
                     !(funct3 == 3'b000 || funct3 == 3'b010 || funct3 == 3'b110 || funct3 == 3'b111)));
            chk("state",       state,                 m_st);
            chk("pc_write",    4'(pc_write),          4'(g & (r.pcu | (r.br & zero))));
            chk("adr_src",     4'(adr_src),           4'(g & r.adr));
            chk("mem_write",   4'(mem_write),         4'(g & r.mw));
            chk("ir_write",    4'(ir_write),          4'(g & r.irw));
            chk("reg_write",   4'(reg_write),         4'(g & r.rw));
            chk("result_src",  4'(result_src),        4'(g ? r.rs : 2'b00));
            chk("alu_src_a",   4'(alu_src_a),         4'(g ? r.sa : 2'b00));
            chk("alu_src_b",   4'(alu_src_b),         4'(g ? r.sb : 2'b00));
            chk("imm_src",     4'(imm_src),           4'(g ? exp_imm(op) : 2'b00));
            chk("alu_control", 4'(alu_control),       4'(g ? exp_alu(r.aop, op, funct3, funct7b5) : 3'b000));
            chk("illegal",     4'(illegal),           4'(g & e_ill));
        end
    end

    logic [6:0] cur_op = 7'b0110011;
    logic [2:0] cur_f3 = 3'b000;
    logic       cur_f7 = 1'b0;
    logic [3:0] obs_aluc [16];
    logic       obs_pcw [16];
    logic       obs_irw [16];
    logic       obs_adr [16];
    logic       obs_rw [16];
    logic       obs_ill [16];
    logic [1:0] obs_rs [16];
    logic [1:0] obs_imm [16];
    int mw_cnt = 0;
    int rw_cnt = 0;

    task automatic cyc(input logic r, input logic [3:0] st, input logic z);
        @(posedge clk); #1;
        rst_n = r; zero = z; op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
        m_rst = r; m_st = st; m_valid = 1'b1;
        @(negedge clk); #1;
        obs_aluc[st] = {1'b0, alu_control};
        obs_pcw[st]  = pc_write;
        obs_irw[st]  = ir_write;
        obs_adr[st]  = adr_src;
        obs_rw[st]   = reg_write;
        obs_ill[st]  = illegal;
        obs_rs[st]   = result_src;
        obs_imm[st]  = imm_src;
        mw_cnt += int'(mem_write);
        rw_cnt += int'(reg_write);
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        logic [3:0] seq [5];
        int n;
        cur_op = o; cur_f3 = f3; cur_f7 = f7;
        mw_cnt = 0; rw_cnt = 0;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd0; seq[3] = 4'd0; seq[4] = 4'd0;
        n = 2;
        case (o)
            7'b0000011: begin seq[2] = 4'd2; seq[3] = 4'd3; seq[4] = 4'd4; n = 5; end
            7'b0100011: begin seq[2] = 4'd2; seq[3] = 4'd5; n = 4; end
            7'b0110011: begin seq[2] = 4'd6; seq[3] = 4'd8; n = 4; end
            7'b0010011: begin seq[2] = 4'd7; seq[3] = 4'd8; n = 4; end
            7'b1100011: begin seq[2] = 4'd9; n = 3; end
            7'b1101111: begin seq[2] = 4'd10; seq[3] = 4'd8; n = 4; end
            default: n = 2;
        endcase
        for (int i = 0; i < n; i++)
            cyc(1'b1, seq[i], (seq[i] == 4'd9) ? z : 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 1'($urandom_range(0, 1)));
        chk("rst_state", state, 4'd0);
        chk("rst_irw", 4'(ir_write), 4'd0);

        instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        chk("rel_irw", 4'(obs_irw[0]), 4'd1);
        chk("rel_pcw", 4'(obs_pcw[0]), 4'd1);
        chk("rel_aluc", obs_aluc[0], 4'd0);
        chk("sub_aluc", obs_aluc[6], 4'd1);

        instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        chk("lw_imm", 4'(obs_imm[2]), 4'd0);
        chk("lw_adr", 4'(obs_adr[3]), 4'd1);
        chk("lw_rs", 4'(obs_rs[4]), 4'd1);
        chk("lw_rwcnt", 4'(rw_cnt), 4'd1);

        instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        chk("add_aluc", obs_aluc[6], 4'd0);
        instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        chk("addi_aluc", obs_aluc[7], 4'd0);
        instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        chk("slt_aluc", obs_aluc[6], 4'd5);
        instr(7'b0110011, 3'b110, 1'b0, 1'b0);
        chk("or_aluc", obs_aluc[6], 4'd3);
        instr(7'b0010011, 3'b111, 1'b0, 1'b0);
        chk("andi_aluc", obs_aluc[7], 4'd2);

        instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        chk("beq_t_pcw", 4'(obs_pcw[9]), 4'd1);
        chk("beq_aluc", obs_aluc[9], 4'd1);
        chk("beq_imm", 4'(obs_imm[9]), 4'd2);
        instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        chk("beq_nt_pcw", 4'(obs_pcw[9]), 4'd0);

        instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        chk("jal_pcw", 4'(obs_pcw[10]), 4'd1);
        chk("jal_rw", 4'(obs_rw[8]), 4'd1);

        instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        chk("ill_pulse", 4'(obs_ill[1]), 4'd1);

        cur_op = 7'b0100011; cur_f3 = 3'b010; cur_f7 = 1'b0; mw_cnt = 0;
        cyc(1'b1, 4'd0, 1'b0);
        cyc(1'b1, 4'd1, 1'b1);
        cyc(1'b1, 4'd2, 1'b0);
        cyc(1'b0, 4'd5, 1'b1);
        chk("midrst_mw", 4'(mw_cnt), 4'd0);

        instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        chk("sw_mwcnt", 4'(mw_cnt), 4'd1);
        chk("sw_imm", 4'(obs_imm[1]), 4'd1);

        @(posedge clk); #1;
        m_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
